envelope_vca: RTL and testbench

Per-voice ADSR envelope generator and VCA. Sits directly downstream of the DDS saw oscillator and consumes its signed 16-bit sample stream. Scales each sample by a 16-bit envelope that advances on a sample-rate tick. Output feeds the voice mixer.

---
 rtl/envelope_vca.sv | 176 +++++++++++++++++
 tb/tb_envelope_vca.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/envelope_vca.sv
// envelope_vca: per-voice ADSR envelope generator driving a two-stage VCA multiply.
// The envelope advances only on env_tick cycles; the VCA scales every sample.
// Optional build macro ENV_EXP_RELEASE_EN selects an exponential-like release
// curve (decrement proportional to the current level) instead of a linear one.
module envelope_vca #(
  parameter int DATA_WIDTH = 16,
  parameter int ENV_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_active_high,
  input  logic                         env_tick,
  input  logic                         gate,
  input  logic [ENV_WIDTH-1:0]         attack_rate,
  input  logic [ENV_WIDTH-1:0]         decay_rate,
  input  logic [ENV_WIDTH-1:0]         sustain_level,
  input  logic [ENV_WIDTH-1:0]         release_rate,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  output logic signed [DATA_WIDTH-1:0] audio_out,
  output logic [ENV_WIDTH-1:0]         env_level,
  output logic [2:0]                   env_state,
  output logic                         active
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_e;

  localparam int PROD_WIDTH = DATA_WIDTH + ENV_WIDTH + 1;
  localparam logic [ENV_WIDTH:0] FULL_SCALE = {1'b0, {ENV_WIDTH{1'b1}}};

  env_state_e                   state_q, state_d;
  logic [ENV_WIDTH-1:0]         level_q, level_d;
  logic                         gate_prev_q, gate_prev_d;
  logic                         retrig_pend_q, retrig_pend_d;
  logic signed [PROD_WIDTH-1:0] prod_q, prod_d;
  logic signed [DATA_WIDTH-1:0] audio_q, audio_d;

  logic                         gate_rise;
  logic [ENV_WIDTH:0]           attack_sum;
  logic [ENV_WIDTH:0]           release_dec;
  logic [ENV_WIDTH-1:0]         decay_diff;
  logic signed [PROD_WIDTH-1:0] sample_ext;
  logic signed [PROD_WIDTH-1:0] level_ext;
  logic                         unused_prod_top;

  assign gate_rise       = gate & ~gate_prev_q;
  assign unused_prod_top = prod_q[PROD_WIDTH-1];

`ifdef ENV_EXP_RELEASE_EN
  logic unused_release_hi;
  assign unused_release_hi = ^release_rate[ENV_WIDTH-1:4];

  // Exponential-like release: step shrinks with the level, +1 guarantees progress to zero.
  always_comb begin
    release_dec = ({1'b0, level_q} >> release_rate[3:0]) + (ENV_WIDTH+1)'(1);
  end
`else
  // Linear release: fixed decrement per tick.
  always_comb begin
    release_dec = {1'b0, release_rate};
  end
`endif

  // Gate edge detector; a pending retrigger survives until the next envelope tick consumes it.
  always_comb begin
    gate_prev_d   = gate;
    retrig_pend_d = retrig_pend_q;
    if (env_tick) begin
      retrig_pend_d = 1'b0;
    end else if (gate_rise) begin
      retrig_pend_d = 1'b1;
    end
  end

  // Envelope next-state and level; retrigger keeps the current level so there is no click.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    attack_sum = {1'b0, level_q} + {1'b0, attack_rate};
    decay_diff = level_q - decay_rate;
    if (env_tick) begin
      if (retrig_pend_q || gate_rise) begin
        state_d = ST_ATTACK;
      end else begin
        case (state_q)
          ST_ATTACK: begin
            if (!gate) begin
              state_d = ST_RELEASE;
            end else if (attack_sum >= FULL_SCALE) begin
              level_d = FULL_SCALE[ENV_WIDTH-1:0];
              state_d = ST_DECAY;
            end else begin
              level_d = attack_sum[ENV_WIDTH-1:0];
            end
          end
          ST_DECAY: begin
            if (!gate) begin
              state_d = ST_RELEASE;
            end else if ((level_q < decay_rate) || (decay_diff <= sustain_level)) begin
              level_d = sustain_level;
              state_d = ST_SUSTAIN;
            end else begin
              level_d = decay_diff;
            end
          end
          ST_SUSTAIN: begin
            if (!gate) begin
              state_d = ST_RELEASE;
            end else begin
              level_d = sustain_level;
            end
          end
          ST_RELEASE: begin
            if ({1'b0, level_q} <= release_dec) begin
              level_d = '0;
              state_d = ST_IDLE;
            end else begin
              level_d = level_q - release_dec[ENV_WIDTH-1:0];
            end
          end
          default: begin
            level_d = '0;
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  // VCA datapath: stage 1 multiplies by the registered level, stage 2 rescales by full scale.
  always_comb begin
    sample_ext = PROD_WIDTH'(sample_in);
    level_ext  = PROD_WIDTH'({1'b0, level_q});
    prod_d     = sample_ext * level_ext;
    audio_d    = prod_q[ENV_WIDTH +: DATA_WIDTH];
  end

  // Envelope state register.
  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      state_q <= ST_IDLE;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // Edge-detect and VCA pipeline registers.
  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      gate_prev_q   <= 1'b0;
      retrig_pend_q <= 1'b0;
      prod_q        <= '0;
      audio_q       <= '0;
    end else begin
      gate_prev_q   <= gate_prev_d;
      retrig_pend_q <= retrig_pend_d;
      prod_q        <= prod_d;
      audio_q       <= audio_d;
    end
  end

  // Output decode.
  always_comb begin
    env_state = state_q;
    env_level = level_q;
    audio_out = audio_q;
    active    = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_envelope_vca.sv
// tb_envelope_vca: directed ADSR/VCA steps followed by a random phase, all
// checked against a behavioural envelope model kept in the bench.
module tb_envelope_vca;

  logic               clk = 1'b0;
  logic               rst_active_high;
  logic               env_tick;
  logic               gate;
  logic [15:0]        attack_rate;
  logic [15:0]        decay_rate;
  logic [15:0]        sustain_level;
  logic [15:0]        release_rate;
  logic signed [15:0] sample_in;
  logic signed [15:0] audio_out;
  logic [15:0]        env_level;
  logic [2:0]         env_state;
  logic               active;

  int errors = 0;
  int checks = 0;

  // Behavioural model state: level and phase as plain integers.
  int     m_level;
  int     m_state;
  bit     m_gate_prev;
  bit     m_pend;
  longint m_prod;
  int     m_audio;

  envelope_vca #(.DATA_WIDTH(16), .ENV_WIDTH(16)) dut (
    .clk             (clk),
    .rst_active_high (rst_active_high),
    .env_tick        (env_tick),
    .gate            (gate),
    .attack_rate     (attack_rate),
    .decay_rate      (decay_rate),
    .sustain_level   (sustain_level),
    .release_rate    (release_rate),
    .sample_in       (sample_in),
    .audio_out       (audio_out),
    .env_level       (env_level),
    .env_state       (env_state),
    .active          (active)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    m_level     = 0;
    m_state     = 0;
    m_gate_prev = 1'b0;
    m_pend      = 1'b0;
    m_prod      = 0;
    m_audio     = 0;
  endfunction

  // One clock edge of the reference: VCA uses the level from before this edge.
  function automatic void modelEdge();
    int  atk, dec, sus, rel, rdec;
    bit  rise;
    atk  = int'(attack_rate);
    dec  = int'(decay_rate);
    sus  = int'(sustain_level);
    rel  = int'(release_rate);
    rise = gate && !m_gate_prev;

    m_audio = int'((m_prod >>> 16) & 64'hFFFF);
    m_prod  = longint'(sample_in) * longint'(m_level);

    if (env_tick) begin
      if (m_pend || rise) begin
        m_state = 1;
      end else begin
        case (m_state)
          1: begin
            if (!gate) m_state = 4;
            else if (m_level + atk >= 65535) begin m_level = 65535; m_state = 2; end
            else m_level = m_level + atk;
          end
          2: begin
            if (!gate) m_state = 4;
            else if (m_level - dec <= sus) begin m_level = sus; m_state = 3; end
            else m_level = m_level - dec;
          end
          3: begin
            if (!gate) m_state = 4;
            else m_level = sus;
          end
          4: begin
`ifdef ENV_EXP_RELEASE_EN
            rdec = (m_level >> (rel % 16)) + 1;
`else
            rdec = rel;
`endif
            if (m_level <= rdec) begin m_level = 0; m_state = 0; end
            else m_level = m_level - rdec;
          end
          default: m_level = 0;
        endcase
      end
      m_pend = 1'b0;
    end else if (rise) begin
      m_pend = 1'b1;
    end
    m_gate_prev = gate;
  endfunction

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne({tag, ".env_level"}, {16'h0, env_level}, m_level);
    checkOne({tag, ".env_state"}, {29'h0, env_state}, m_state);
    checkOne({tag, ".active"},    {31'h0, active},    (m_state != 0) ? 1 : 0);
    checkOne({tag, ".audio_out"}, {16'h0, $unsigned(audio_out)}, m_audio);
  endtask

  // Drive one cycle of inputs, advance model on the edge, then compare just after it.
  task automatic applyStimulus(input string tag, input bit t, input bit g, input logic [15:0] s);
    env_tick  = t;
    gate      = g;
    sample_in = s;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst_active_high = 1'b0;
    env_tick        = 1'b0;
    gate            = 1'b0;
    attack_rate     = 16'h0;
    decay_rate      = 16'h0;
    sustain_level   = 16'h0;
    release_rate    = 16'h0;
    sample_in       = 16'sh0;
    modelReset();

    #1 rst_active_high = 1'b1;
    #1;
    checkOutput("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_active_high = 1'b0;
    modelReset();

    // Attack from idle
    attack_rate   = 16'h4000;
    decay_rate    = 16'h1000;
    sustain_level = 16'hC000;
    release_rate  = 16'h2000;
    applyStimulus("trig", 1, 1, 16'($urandom));
    checkOne("trig.state_const", {29'h0, env_state}, 32'd1);
    applyStimulus("atk1", 1, 1, 16'($urandom));
    checkOne("atk1.const", {16'h0, env_level}, 32'h4000);
    applyStimulus("atk2", 1, 1, 16'($urandom));
    checkOne("atk2.const", {16'h0, env_level}, 32'h8000);
    applyStimulus("atk3", 1, 1, 16'($urandom));
    checkOne("atk3.const", {16'h0, env_level}, 32'hC000);
    applyStimulus("atk4", 1, 1, 16'($urandom));
    checkOne("atk4.const", {16'h0, env_level}, 32'hFFFF);
    checkOne("atk4.state_const", {29'h0, env_state}, 32'd2);
    checkOne("atk4.active_const", {31'h0, active}, 32'd1);

    // Decay to sustain, then live sustain change
    applyStimulus("dec1", 1, 1, 16'($urandom));
    checkOne("dec1.const", {16'h0, env_level}, 32'hEFFF);
    applyStimulus("dec2", 1, 1, 16'($urandom));
    applyStimulus("dec3", 1, 1, 16'($urandom));
    checkOne("dec3.const", {16'h0, env_level}, 32'hCFFF);
    applyStimulus("dec4", 1, 1, 16'($urandom));
    checkOne("dec4.const", {16'h0, env_level}, 32'hC000);
    checkOne("dec4.state_const", {29'h0, env_state}, 32'd3);
    sustain_level = 16'h8000;
    applyStimulus("sus_live", 1, 1, 16'($urandom));
    checkOne("sus_live.const", {16'h0, env_level}, 32'h8000);

    // Release from 0x3000
    sustain_level = 16'h3000;
    applyStimulus("sus3000", 1, 1, 16'($urandom));
    applyStimulus("rel0", 1, 0, 16'($urandom));
    checkOne("rel0.state_const", {29'h0, env_state}, 32'd4);
    applyStimulus("rel1", 1, 0, 16'($urandom));
    applyStimulus("rel2", 1, 0, 16'($urandom));
`ifndef ENV_EXP_RELEASE_EN
    checkOne("rel2.const", {16'h0, env_level}, 32'h0);
    checkOne("rel2.active_const", {31'h0, active}, 32'd0);
`endif

    // VCA at full scale: decay rate 0 parks the level at 0xFFFF
    attack_rate   = 16'h8000;
    decay_rate    = 16'h0;
    sustain_level = 16'h0;
    applyStimulus("vca_trig", 1, 1, 16'($urandom));
    applyStimulus("vca_atk1", 1, 1, 16'($urandom));
    applyStimulus("vca_atk2", 1, 1, 16'($urandom));
    applyStimulus("vca_hold", 1, 1, 16'($urandom));
    checkOne("vca_hold.const", {16'h0, env_level}, 32'hFFFF);
    applyStimulus("vca_pos0", 0, 1, 16'h7FFF);
    applyStimulus("vca_pos1", 0, 1, 16'h7FFF);
    checkOne("vca_pos.const", {16'h0, $unsigned(audio_out)}, 32'h7FFE);
    applyStimulus("vca_neg0", 0, 1, 16'h8000);
    applyStimulus("vca_neg1", 0, 1, 16'h8000);
    checkOne("vca_neg.const", {16'h0, $unsigned(audio_out)}, 32'h8000);
    release_rate = 16'hFFF0;
    for (int i = 0; i < 4; i++) applyStimulus("vca_rel", 1, 0, 16'($urandom));
    applyStimulus("vca_zero0", 0, 0, 16'h7FFF);
    applyStimulus("vca_zero1", 0, 0, 16'h7FFF);
    checkOne("vca_zero.const", {16'h0, $unsigned(audio_out)}, 32'h0);

    // Retrigger during release keeps the level
    attack_rate   = 16'h8000;
    decay_rate    = 16'h4000;
    sustain_level = 16'h4000;
    release_rate  = 16'h2000;
    for (int i = 0; i < 6; i++) applyStimulus("rt_build", 1, 1, 16'($urandom));
    checkOne("rt_sus.const", {16'h0, env_level}, 32'h4000);
    applyStimulus("rt_rel0", 1, 0, 16'($urandom));
    applyStimulus("rt_rel1", 1, 0, 16'($urandom));
`ifndef ENV_EXP_RELEASE_EN
    checkOne("rt_rel1.const", {16'h0, env_level}, 32'h2000);
`endif
    applyStimulus("rt_trig", 1, 1, 16'($urandom));
    checkOne("rt_trig.state_const", {29'h0, env_state}, 32'd1);
    attack_rate = 16'h1000;
    applyStimulus("rt_atk", 1, 1, 16'($urandom));
`ifndef ENV_EXP_RELEASE_EN
    checkOne("rt_atk.const", {16'h0, env_level}, 32'h3000);
`endif

    // Asynchronous reset mid-attack, observed before any clock edge
    rst_active_high = 1'b1;
    #1;
    modelReset();
    checkOutput("async_rst");
    checkOne("async_rst.level_const", {16'h0, env_level}, 32'h0);
    @(posedge clk);
    #1;
    rst_active_high = 1'b0;

`ifdef ENV_EXP_RELEASE_EN
    // Exponential release step from 0x8000 with shift 4
    attack_rate   = 16'h8000;
    decay_rate    = 16'h4000;
    sustain_level = 16'h8000;
    for (int i = 0; i < 5; i++) applyStimulus("exp_build", 1, 1, 16'($urandom));
    applyStimulus("exp_rel0", 1, 0, 16'($urandom));
    release_rate = 16'h0004;
    applyStimulus("exp_rel1", 1, 0, 16'($urandom));
    checkOne("exp_rel1.const", {16'h0, env_level}, 32'h77FF);
`endif

    // Random phase
    gate = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) attack_rate   = 16'($urandom_range(0, 16'h6000));
      if ($urandom_range(0, 31) == 0) decay_rate    = 16'($urandom_range(0, 16'h3000));
      if ($urandom_range(0, 31) == 0) sustain_level = 16'($urandom);
      if ($urandom_range(0, 31) == 0) release_rate  = 16'($urandom_range(0, 16'h3000));
      applyStimulus("rand", ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 11) == 0) ? ~gate : gate, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
